// File: rtl/delta_frame_seq.sv
// delta_frame_seq: frame-level sequencer for the delta_frame datapath.
// Tracks pixel/line position, schedules base-frame captures and aligns
// delta_frame enable/threshold changes to frame boundaries.
//
// Ports:
//   clk, aresetn     clock, asynchronous active-low reset
//   pix_valid        current pixel valid
//   pix_sof          first pixel of frame (qualified by pix_valid)
//   capture_req      pulse: capture the next full frame as base
//   delta_req        level: delta mode wanted (else pass-through)
//   threshold_in     software threshold
//   threshold        threshold to delta_frame, changes only at SOF
//   delta_enable     enable to delta_frame
//   base_wr/base_rd  base-buffer write/read strobes for current pixel
//   base_addr        linear pixel address v*H_ACTIVE+h
//   h_count/v_count  column/line of current pixel
//   base_valid       a complete base frame is stored
//   capture_busy     capture pending or in progress
//   frame_err        sticky malformed-frame flag

module delta_frame_seq #(
    parameter int INPUT_WIDTH = 10,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int ADDR_W      = 19,
    parameter int CNT_W       = 11
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   pix_valid,
    input  logic                   pix_sof,
    input  logic                   capture_req,
    input  logic                   delta_req,
    input  logic [INPUT_WIDTH-1:0] threshold_in,
    output logic [INPUT_WIDTH-1:0] threshold,
    output logic                   delta_enable,
    output logic                   base_wr,
    output logic                   base_rd,
    output logic [ADDR_W-1:0]      base_addr,
    output logic [CNT_W-1:0]       h_count,
    output logic [CNT_W-1:0]       v_count,
    output logic                   base_valid,
    output logic                   capture_busy,
    output logic                   frame_err
);

    typedef enum logic [1:0] {
        WAIT_SOF = 2'd0,
        PASS     = 2'd1,
        CAPTURE  = 2'd2,
        DELTA    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_ACTIVE - 1);

    state_t state_q, state_d, eff_state;

    logic                   pend_q, pend_d;
    logic                   bv_q, bv_d;
    logic                   err_q, err_d;
    logic                   done_q, done_d;
    logic [INPUT_WIDTH-1:0] thr_q, thr_d;
    logic [CNT_W-1:0]       h_q, h_d, v_q, v_d;
    logic [ADDR_W-1:0]      a_q, a_d;

    logic              sof;
    logic              go_cap;
    logic              bv_sof;
    logic              bv_next;
    logic              act;
    logic              last;
    logic              short_frame;
    logic              overrun;
    logic [CNT_W-1:0]  cur_h, cur_v;
    logic [ADDR_W-1:0] cur_a;

    assign sof = pix_valid & pix_sof;

    // State and datapath registers
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= WAIT_SOF;
            pend_q  <= 1'b0;
            bv_q    <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
            thr_q   <= '0;
            h_q     <= '0;
            v_q     <= '0;
            a_q     <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            bv_q    <= bv_d;
            err_q   <= err_d;
            done_q  <= done_d;
            thr_q   <= thr_d;
            h_q     <= h_d;
            v_q     <= v_d;
            a_q     <= a_d;
        end
    end

    // Next-state and frame bookkeeping
    always_comb begin
        state_d = state_q;
        pend_d  = pend_q | capture_req;
        bv_d    = bv_q;
        thr_d   = thr_q;

        go_cap  = pend_q | capture_req;
        // A base becomes valid only when a capture frame ran to completion;
        // starting a new capture overwrites whatever was stored.
        bv_sof  = (state_q == CAPTURE && done_q) ? 1'b1 : bv_q;
        bv_next = go_cap ? 1'b0 : bv_sof;

        if (sof) begin
            pend_d = 1'b0;
            bv_d   = bv_next;
            thr_d  = threshold_in;
            if (go_cap) begin
                state_d = CAPTURE;
            end else if (delta_req && bv_next) begin
                state_d = DELTA;
            end else begin
                state_d = PASS;
            end
        end

        short_frame = sof && (state_q != WAIT_SOF) && !done_q;
        overrun     = pix_valid && !pix_sof
                   && (state_q != WAIT_SOF) && done_q;
        err_d       = err_q | short_frame | overrun;
    end

    // SOF cycles act on the incoming mode so the SOF pixel is aligned
    assign eff_state = sof ? state_d : state_q;

    // Position counters: registers hold the position of the next pixel,
    // or of the last pixel once the frame is done.
    always_comb begin
        cur_h  = sof ? '0 : h_q;
        cur_v  = sof ? '0 : v_q;
        cur_a  = sof ? '0 : a_q;
        act    = pix_valid && (eff_state != WAIT_SOF) && (sof || !done_q);
        last   = (cur_h == H_LAST) && (cur_v == V_LAST);

        h_d    = h_q;
        v_d    = v_q;
        a_d    = a_q;
        done_d = sof ? 1'b0 : done_q;

        if (act) begin
            if (last) begin
                h_d    = cur_h;
                v_d    = cur_v;
                a_d    = cur_a;
                done_d = 1'b1;
            end else if (cur_h == H_LAST) begin
                h_d = '0;
                v_d = cur_v + CNT_W'(1);
                a_d = cur_a + ADDR_W'(1);
            end else begin
                h_d = cur_h + CNT_W'(1);
                v_d = cur_v;
                a_d = cur_a + ADDR_W'(1);
            end
        end
    end

    // Outputs
    always_comb begin
        base_wr      = 1'b0;
        base_rd      = 1'b0;
        delta_enable = 1'b0;
        if (act) begin
            unique case (1'b1)
                eff_state == CAPTURE: base_wr = 1'b1;
                eff_state == DELTA: begin
                    base_rd      = 1'b1;
                    delta_enable = 1'b1;
                end
                default: ;
            endcase
        end

        threshold    = sof ? threshold_in : thr_q;
        base_addr    = cur_a;
        h_count      = cur_h;
        v_count      = cur_v;
        base_valid   = sof ? bv_next : bv_q;
        capture_busy = sof ? (state_d == CAPTURE)
                           : (pend_q | (state_q == CAPTURE));
        frame_err    = err_q;
    end

endmodule

// File: tb/tb_delta_frame_seq.sv
// tb_delta_frame_seq: directed table-driven bench for delta_frame_seq
// with a 4x2 frame, plus short hand-written corner sequences.

module tb_delta_frame_seq;

    localparam int IW = 10;
    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 19;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          aresetn;
    logic          pix_valid, pix_sof, capture_req, delta_req;
    logic [IW-1:0] threshold_in;
    logic [IW-1:0] threshold;
    logic          delta_enable, base_wr, base_rd;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] h_count, v_count;
    logic          base_valid, capture_busy, frame_err;

    always #5 clk = ~clk;

    delta_frame_seq #(
        .INPUT_WIDTH(IW), .H_ACTIVE(H), .V_ACTIVE(V),
        .ADDR_W(AW), .CNT_W(CW)
    ) dut (
        .clk(clk), .aresetn(aresetn),
        .pix_valid(pix_valid), .pix_sof(pix_sof),
        .capture_req(capture_req), .delta_req(delta_req),
        .threshold_in(threshold_in), .threshold(threshold),
        .delta_enable(delta_enable), .base_wr(base_wr),
        .base_rd(base_rd), .base_addr(base_addr),
        .h_count(h_count), .v_count(v_count),
        .base_valid(base_valid), .capture_busy(capture_busy),
        .frame_err(frame_err)
    );

    typedef struct {
        logic          rst, pv, ps, cr, dr;
        logic [IW-1:0] ti;
        logic          wr, rd, de;
        logic [AW-1:0] a;
        logic [CW-1:0] h, v;
        logic          bv, bz, er;
        logic [IW-1:0] th;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    task automatic add(input logic r, pv, ps, cr, dr, input int ti,
                       input logic wr, rd, de, input int a, h, v,
                       input logic bv, bz, er, input int th);
        vec_t x;
        x.rst = r;  x.pv = pv; x.ps = ps; x.cr = cr; x.dr = dr;
        x.ti  = ti[IW-1:0];
        x.wr  = wr; x.rd = rd; x.de = de;
        x.a   = a[AW-1:0];
        x.h   = h[CW-1:0];
        x.v   = v[CW-1:0];
        x.bv  = bv; x.bz = bz; x.er = er;
        x.th  = th[IW-1:0];
        vecs.push_back(x);
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack_dut();
        return 64'({base_wr, base_rd, delta_enable, base_addr,
                    h_count, v_count, base_valid, capture_busy,
                    frame_err, threshold});
    endfunction

    function automatic logic [63:0] pack_exp(input vec_t x);
        return 64'({x.wr, x.rd, x.de, x.a, x.h, x.v,
                    x.bv, x.bz, x.er, x.th});
    endfunction

    initial begin
        aresetn = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        capture_req = 1'b0; delta_req = 1'b0; threshold_in = '0;

        // reset state
        add(1,0,0,0,0,20, 0,0,0,0,0,0, 0,0,0,0);
        // valid non-SOF pixels in WAIT_SOF are ignored
        for (int k = 0; k < 3; k++)
            add(0,1,0,0,0,20, 0,0,0,0,0,0, 0,0,0,0);
        // frame 1: PASS, capture_req mid-frame, threshold_in 20->35
        add(0,1,1,0,0,20, 0,0,0,0,0,0, 0,0,0,20);
        add(0,1,0,0,0,20, 0,0,0,1,1,0, 0,0,0,20);
        add(0,1,0,1,1,20, 0,0,0,2,2,0, 0,0,0,20);
        add(0,0,0,0,1,20, 0,0,0,3,3,0, 0,1,0,20);
        add(0,1,0,0,1,35, 0,0,0,3,3,0, 0,1,0,20);
        for (int k = 4; k < 8; k++)
            add(0,1,0,0,1,35, 0,0,0,k,k%4,k/4, 0,1,0,20);
        // frame 2: CAPTURE, writes addr 0..7
        add(0,1,1,0,1,35, 1,0,0,0,0,0, 0,1,0,35);
        for (int k = 1; k < 8; k++)
            add(0,1,0,0,1,35, 1,0,0,k,k%4,k/4, 0,1,0,35);
        add(0,0,0,0,1,35, 0,0,0,7,3,1, 0,1,0,35);
        // frame 3: DELTA, base valid from the SOF pixel on
        add(0,1,1,0,1,35, 0,1,1,0,0,0, 1,0,0,35);
        for (int k = 1; k < 8; k++)
            add(0,1,0,0,1,35, 0,1,1,k,k%4,k/4, 1,0,0,35);
        // frame 4: capture_req with SOF while in DELTA, cut short
        add(0,1,1,1,1,35, 1,0,0,0,0,0, 0,1,0,35);
        for (int k = 1; k < 5; k++)
            add(0,1,0,0,1,35, 1,0,0,k,k%4,k/4, 0,1,0,35);
        // short SOF: error, no base, so PASS despite delta_req
        add(0,1,1,0,1,35, 0,0,0,0,0,0, 0,0,0,35);
        for (int k = 1; k < 8; k++)
            add(0,1,0,0,1,35, 0,0,0,k,k%4,k/4, 0,0,1,35);
        // 9th pixel ignored, counters hold
        add(0,1,0,0,1,35, 0,0,0,7,3,1, 0,0,1,35);
        add(0,1,1,0,0,35, 0,0,0,0,0,0, 0,0,1,35);
        add(0,1,0,0,0,35, 0,0,0,1,1,0, 0,0,1,35);
        // reset mid-frame
        add(1,1,0,0,0,35, 0,0,0,0,0,0, 0,0,0,0);
        add(0,1,0,0,0,35, 0,0,0,0,0,0, 0,0,0,0);
        // clean frame then overrun pixel
        add(0,1,1,0,0,20, 0,0,0,0,0,0, 0,0,0,20);
        for (int k = 1; k < 8; k++)
            add(0,1,0,0,0,20, 0,0,0,k,k%4,k/4, 0,0,0,20);
        add(0,1,0,0,0,20, 0,0,0,7,3,1, 0,0,0,20);
        add(0,0,0,0,0,20, 0,0,0,7,3,1, 0,0,1,20);

        repeat (2) @(negedge clk);

        foreach (vecs[i]) begin
            @(negedge clk);
            aresetn      = !vecs[i].rst;
            pix_valid    = vecs[i].pv;
            pix_sof      = vecs[i].ps;
            capture_req  = vecs[i].cr;
            delta_req    = vecs[i].dr;
            threshold_in = vecs[i].ti;
            #2;
            chk($sformatf("row%0d", i), pack_dut(), pack_exp(vecs[i]));
        end

        // capture_req while waiting for the first SOF
        @(negedge clk);
        aresetn = 1'b0; pix_valid = 1'b0; pix_sof = 1'b0;
        capture_req = 1'b0; delta_req = 1'b0;
        #2 chk("rst_busy", 64'(capture_busy), 64'd0);
        @(negedge clk);
        aresetn = 1'b1; capture_req = 1'b1;
        #2 chk("req_busy0", 64'(capture_busy), 64'd0);
        @(negedge clk);
        capture_req = 1'b0;
        #2 chk("pend_busy", 64'(capture_busy), 64'd1);
        @(negedge clk);
        pix_valid = 1'b1; pix_sof = 1'b1;
        #2 chk("cap_sof", 64'({base_wr, delta_enable, base_valid}),
               64'(3'b100));
        @(negedge clk);
        pix_sof = 1'b0;
        #2 chk("cap_px1", 64'({base_wr, base_addr}),
               64'({1'b1, 19'd1}));
        @(negedge clk);
        pix_sof = 1'b1; delta_req = 1'b1;
        #2 chk("short_sof", 64'({base_wr, base_rd, delta_enable,
                                 base_valid, frame_err}),
               64'(5'b00000));
        @(negedge clk);
        pix_valid = 1'b0; pix_sof = 1'b0;
        #2 chk("short_err", 64'({frame_err, capture_busy}),
               64'(2'b10));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/delta_frame_seq.md
Name: delta_frame_seq

Overview:
Frame-level sequencer for the delta_frame datapath. It tracks the incoming grayscale pixel stream, counts pixel and line positions, and schedules a base-frame capture into the external base buffer on request. It drives delta_frame's enable and threshold so that every change takes effect exactly on a frame boundary. It sits between the video decoder/grayscale stage and the base-buffer memory plus delta_frame instance.

Parameters:
INPUT_WIDTH, 10, pixel/threshold width (matches delta_frame)
H_ACTIVE, 640, active pixels per line
V_ACTIVE, 480, active lines per frame
ADDR_W, 19, base-buffer address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE
CNT_W, 11, width of h/v counters

Ports:
clk  in  1  system clock
aresetn  in  1  asynchronous active-low reset
pix_valid  in  1  current pixel valid
pix_sof  in  1  first pixel of frame; qualified by pix_valid
capture_req  in  1  single-cycle pulse: capture next full frame as base
delta_req  in  1  level: 1 = delta mode wanted, 0 = pass-through
threshold_in  in  INPUT_WIDTH  software threshold
threshold  out  INPUT_WIDTH  threshold to delta_frame; changes only at SOF
delta_enable  out  1  enable to delta_frame
base_wr  out  1  write current pixel to base buffer
base_rd  out  1  read base pixel at base_addr
base_addr  out  ADDR_W  linear pixel address, v*H_ACTIVE+h
h_count  out  CNT_W  column of current pixel
v_count  out  CNT_W  line of current pixel
base_valid  out  1  a complete base frame is stored
capture_busy  out  1  capture pending or in progress
frame_err  out  1  sticky; malformed frame seen

Behaviour:
- Reset (async, aresetn=0): state=WAIT_SOF. All counters=0, threshold reg=0, capture_pend=0, base_valid=0, frame_err=0. All outputs 0.
- SOF event = pix_valid & pix_sof. Pixels with pix_valid=1 and no SOF while in WAIT_SOF are ignored: no rd/wr, counters hold.
- States: WAIT_SOF, PASS, CAPTURE, DELTA. Transitions occur only on an SOF event. Next state is selected in priority order:
  1. capture_pend=1 or capture_req=1 -> CAPTURE; capture_pend clears.
  2. delta_req=1 and base_valid_next=1 -> DELTA.
  3. Otherwise -> PASS.
- base_valid_next = 1 when the frame just ended in CAPTURE completed all H_ACTIVE*V_ACTIVE pixels. base_valid_next = 0 when entering CAPTURE, because the old base is overwritten. Otherwise base_valid_next = base_valid.
- capture_req arriving mid-frame sets capture_pend. A capture_req coinciding with an SOF starts capture on that SOF.
- Zero-latency control: on an SOF cycle, outputs reflect the next state, so the SOF pixel already belongs to the new mode. On other cycles, outputs reflect the registered state. This alignment is required because delta_frame samples enable with the same pixel.
- threshold = threshold_in on an SOF cycle, else the latched value. The latch updates on each SOF event.
- Counters:
  - On an SOF event: h=0, v=0, addr=0 for that pixel.
  - On each later valid pixel: h+1. When h=H_ACTIVE-1, h wraps to 0 and v increments.
  - addr increments by 1 per valid pixel.
  - After the last pixel (h=H_ACTIVE-1, v=V_ACTIVE-1), frame_done=1 and counters hold.
- Per-pixel outputs, asserted only when pix_valid=1, the pixel lies inside the frame, and state is not WAIT_SOF:
  - CAPTURE: base_wr=1, delta_enable=0.
  - DELTA: base_rd=1, delta_enable=1.
  - PASS: none of the above, delta_enable=0.
- delta_enable is 0 on invalid cycles.
- capture_busy = capture_pend | (state==CAPTURE).
- Errors (frame_err sticky until reset):
  - Valid non-SOF pixel after frame_done: ignored, no rd/wr.
  - SOF before frame_done while not in WAIT_SOF (short frame). If the short frame was in CAPTURE, base_valid stays 0. A new SOF handles it normally per the priority rules.
- delta_req deasserted mid-frame has no effect until the next SOF.

Test Plan (H_ACTIVE=4, V_ACTIVE=2):
- Reset, stream 3 valid non-SOF pixels then SOF frame -> no rd/wr before SOF; SOF pixel h=0,v=0,addr=0; state PASS; delta_enable=0 throughout.
- capture_req mid-frame 1, delta_req=1 -> frame 1 PASS; frame 2 base_wr on 8 pixels with addr 0..7; base_valid=1 at frame 3 SOF; frame 3 delta_enable=1 and base_rd=1 on SOF pixel and addr 0..7.
- threshold_in changes 20->35 mid-frame -> threshold stays 20 until next SOF cycle, then 35 that same cycle.
- SOF after 5 pixels during CAPTURE -> frame_err=1; base_valid stays 0; with delta_req=1 next frame is PASS.
- 9th valid pixel without SOF -> frame_err=1; no base_wr/base_rd; h=3,v=1 hold.
- capture_req coincident with SOF while in DELTA -> that SOF pixel has base_wr=1, delta_enable=0, base_valid drops to 0; aresetn low mid-frame -> all outputs 0, state WAIT_SOF.
